// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART: register map, CON bit layout,
// parity encodings and the frame FSM states used by both TX and RX.
package uart_pkg;

  localparam logic [31:0] OFS_TXD = 32'd0;
  localparam logic [31:0] OFS_RXD = 32'd4;
  localparam logic [31:0] OFS_CON = 32'd8;
  localparam logic [31:0] OFS_DIV = 32'd12;

  localparam int CON_TX_IE    = 0;
  localparam int CON_RX_IE    = 1;
  localparam int CON_TX_EMPTY = 2;
  localparam int CON_RX_AVAIL = 3;
  localparam int CON_TX_BUSY  = 4;
  localparam int CON_TX_FULL  = 5;
  localparam int CON_OVR      = 6;
  localparam int CON_FE       = 7;
  localparam int CON_PE       = 8;
  localparam int CON_PAR_LO   = 9;
  localparam int CON_TWO_STOP = 11;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } uart_state_e;

  // 2'b11 is deliberately treated like PAR_NONE.
  function automatic logic par_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  function automatic logic par_bit(input logic [7:0] d, input logic [1:0] mode);
    return (mode == PAR_ODD) ? ~^d : ^d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with power-of-two depth; a pop in the same cycle frees
// room so a push into a full FIFO is still accepted.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push, w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_fifo_unit.sv
// Memory-mapped UART: baud tick generator, TX/RX frame FSMs with optional
// parity and two stop bits, TX/RX FIFOs, sticky error flags and a level irq.
module uart_fifo_unit
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h40000018,
  parameter int          FIFO_DEPTH  = 8,
  parameter int          OVERSAMPLE  = 16,
  parameter int          DIV_W       = 16,
  parameter int          DEFAULT_DIV = 31
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        out,
  input  logic        in,
  output logic        irq
);
  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

  logic w_hit_txd, w_hit_rxd, w_hit_con, w_hit_div;
  logic w_wr_txd, w_wr_con, w_wr_div, w_rd_rxd;
  assign w_hit_txd = (addr == BASE_ADDR + OFS_TXD);
  assign w_hit_rxd = (addr == BASE_ADDR + OFS_RXD);
  assign w_hit_con = (addr == BASE_ADDR + OFS_CON);
  assign w_hit_div = (addr == BASE_ADDR + OFS_DIV);
  assign w_wr_txd  = wr & w_hit_txd;
  assign w_wr_con  = wr & w_hit_con;
  assign w_wr_div  = wr & w_hit_div;
  assign w_rd_rxd  = rd & w_hit_rxd;

  logic             r_tx_ie, r_rx_ie, r_two, r_ovr, r_fe, r_pe, r_irq;
  logic [1:0]       r_par;
  logic [DIV_W-1:0] r_div, r_div_cnt;
  logic             w_tick;

  logic [7:0]    w_txf_data, w_rxf_data, r_rx_shift;
  logic          w_txf_full, w_txf_empty, w_rxf_full, w_rxf_empty;
  logic [CW-1:0] w_txf_count, w_rxf_count;
  logic          w_tx_pop, w_rx_push, w_rx_pop;
  logic          w_set_ovr, w_set_fe, w_set_pe;
  logic          w_unused;
  assign w_unused = ^{wdata[31:16], w_txf_count, w_rxf_count};

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(CLK), .rst_n(Reset_n), .i_push(w_wr_txd), .i_pop(w_tx_pop),
    .i_wdata(wdata[7:0]), .o_rdata(w_txf_data), .o_full(w_txf_full),
    .o_empty(w_txf_empty), .o_count(w_txf_count));

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(CLK), .rst_n(Reset_n), .i_push(w_rx_push), .i_pop(w_rx_pop),
    .i_wdata(r_rx_shift), .o_rdata(w_rxf_data), .o_full(w_rxf_full),
    .o_empty(w_rxf_empty), .o_count(w_rxf_count));

  assign w_rx_pop = w_rd_rxd & ~w_rxf_empty;

  // Baud tick; a DIV write restarts the period so the new rate applies at once.
  assign w_tick = (r_div_cnt == r_div);
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)               r_div_cnt <= '0;
    else if (w_wr_div | w_tick) r_div_cnt <= '0;
    else                        r_div_cnt <= r_div_cnt + 1'b1;
  end

  // ---------------- TX ----------------
  uart_state_e     r_tx_state, w_tx_next;
  logic [OS_W-1:0] r_tx_os;
  logic [2:0]      r_tx_bit;
  logic [7:0]      r_tx_shift;
  logic            r_tx_par, r_tx_par_on, r_tx_two, r_tx_stop2, r_out;
  logic            w_tx_bit_end;

  assign w_tx_bit_end = w_tick & (r_tx_os == OS_LAST);

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      ST_IDLE:   if (w_tick & ~w_txf_empty) begin w_tx_pop = 1'b1; w_tx_next = ST_START; end
      ST_START:  if (w_tx_bit_end) w_tx_next = ST_DATA;
      ST_DATA:   if (w_tx_bit_end && r_tx_bit == 3'd7)
                   w_tx_next = r_tx_par_on ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_tx_bit_end) w_tx_next = ST_STOP;
      ST_STOP:   if (w_tx_bit_end && (!r_tx_two || r_tx_stop2)) begin
                   // Chain straight into the next start bit when data waits.
                   if (!w_txf_empty) begin w_tx_pop = 1'b1; w_tx_next = ST_START; end
                   else w_tx_next = ST_IDLE;
                 end
      default:   w_tx_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) r_tx_state <= ST_IDLE;
    else          r_tx_state <= w_tx_next;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_tx_os <= '0; r_tx_bit <= '0; r_tx_shift <= '0; r_tx_par <= 1'b0;
      r_tx_par_on <= 1'b0; r_tx_two <= 1'b0; r_tx_stop2 <= 1'b0; r_out <= 1'b1;
    end else begin
      if (w_tick)
        r_tx_os <= (w_tx_bit_end || r_tx_state == ST_IDLE) ? '0 : r_tx_os + 1'b1;
      if (w_tx_pop) begin
        r_tx_shift  <= w_txf_data;
        r_tx_par    <= par_bit(w_txf_data, r_par);
        r_tx_par_on <= par_on(r_par);
        r_tx_two    <= r_two;
        r_tx_stop2  <= 1'b0;
        r_tx_bit    <= '0;
        r_out       <= 1'b0;
      end else if (w_tx_bit_end) begin
        case (r_tx_state)
          ST_START: r_out <= r_tx_shift[0];
          ST_DATA: begin
            r_tx_bit <= r_tx_bit + 1'b1;
            if (r_tx_bit == 3'd7) r_out <= r_tx_par_on ? r_tx_par : 1'b1;
            else begin
              r_tx_shift <= r_tx_shift >> 1;
              r_out      <= r_tx_shift[1];
            end
          end
          ST_PARITY: r_out <= 1'b1;
          ST_STOP:   r_tx_stop2 <= 1'b1;
          default:   r_out <= 1'b1;
        endcase
      end
    end
  end
  assign out = r_out;

  // ---------------- RX ----------------
  uart_state_e     r_rx_state, w_rx_next;
  logic            r_rx_s1, r_rx_s2, r_rx_prev, r_rx_perr;
  logic [OS_W-1:0] r_rx_os;
  logic [2:0]      r_rx_bit;
  logic [1:0]      r_rx_mode;
  logic            w_rx_end, w_rx_mid;

  assign w_rx_end = w_tick & (r_rx_os == OS_LAST);
  assign w_rx_mid = w_tick & (r_rx_os == OS_HALF);

  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_push = 1'b0;
    w_set_fe  = 1'b0;
    w_set_pe  = 1'b0;
    case (r_rx_state)
      ST_IDLE:   if (r_rx_prev & ~r_rx_s2) w_rx_next = ST_START;
      ST_START:  if (w_rx_mid) w_rx_next = r_rx_s2 ? ST_IDLE : ST_DATA;
      ST_DATA:   if (w_rx_end && r_rx_bit == 3'd7)
                   w_rx_next = par_on(r_rx_mode) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_rx_end) w_rx_next = ST_STOP;
      ST_STOP:   if (w_rx_end) begin
                   w_rx_next = ST_IDLE;
                   if (r_rx_s2) begin w_rx_push = 1'b1; w_set_pe = r_rx_perr; end
                   else w_set_fe = 1'b1;
                 end
      default:   w_rx_next = ST_IDLE;
    endcase
  end
  assign w_set_ovr = w_rx_push & w_rxf_full & ~w_rx_pop;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) r_rx_state <= ST_IDLE;
    else          r_rx_state <= w_rx_next;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_prev <= 1'b1; r_rx_perr <= 1'b0;
      r_rx_os <= '0; r_rx_bit <= '0; r_rx_mode <= PAR_NONE; r_rx_shift <= '0;
    end else begin
      r_rx_s1   <= in;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      if (r_rx_state == ST_IDLE) begin
        r_rx_os   <= '0;
        r_rx_bit  <= '0;
        r_rx_perr <= 1'b0;
        r_rx_mode <= r_par;
      end else if (w_tick) begin
        r_rx_os <= (w_rx_end || (r_rx_state == ST_START && w_rx_mid)) ? '0 : r_rx_os + 1'b1;
      end
      if (r_rx_state == ST_DATA && w_rx_end) begin
        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 1'b1;
      end
      if (r_rx_state == ST_PARITY && w_rx_end)
        r_rx_perr <= (r_rx_s2 != par_bit(r_rx_shift, r_rx_mode));
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_tx_ie <= 1'b0; r_rx_ie <= 1'b0; r_par <= PAR_NONE; r_two <= 1'b0;
      r_ovr <= 1'b0; r_fe <= 1'b0; r_pe <= 1'b0; r_irq <= 1'b0;
      r_div <= DIV_W'(DEFAULT_DIV);
    end else begin
      if (w_wr_con) begin
        r_tx_ie <= wdata[CON_TX_IE];
        r_rx_ie <= wdata[CON_RX_IE];
        r_par   <= wdata[CON_PAR_LO+1:CON_PAR_LO];
        r_two   <= wdata[CON_TWO_STOP];
      end
      if (w_wr_div) r_div <= wdata[DIV_W-1:0];
      // A set event wins over a simultaneous write-one-to-clear.
      r_ovr <= (r_ovr & ~(w_wr_con & wdata[CON_OVR])) | w_set_ovr;
      r_fe  <= (r_fe  & ~(w_wr_con & wdata[CON_FE]))  | w_set_fe;
      r_pe  <= (r_pe  & ~(w_wr_con & wdata[CON_PE]))  | w_set_pe;
      r_irq <= (r_tx_ie & w_txf_empty & (r_tx_state == ST_IDLE)) |
               (r_rx_ie & ~w_rxf_empty);
    end
  end
  assign irq = r_irq;

  logic [31:0] w_con;
  always_comb begin
    w_con                            = '0;
    w_con[CON_TX_IE]                 = r_tx_ie;
    w_con[CON_RX_IE]                 = r_rx_ie;
    w_con[CON_TX_EMPTY]              = w_txf_empty & (r_tx_state == ST_IDLE);
    w_con[CON_RX_AVAIL]              = ~w_rxf_empty;
    w_con[CON_TX_BUSY]               = (r_tx_state != ST_IDLE);
    w_con[CON_TX_FULL]               = w_txf_full;
    w_con[CON_OVR]                   = r_ovr;
    w_con[CON_FE]                    = r_fe;
    w_con[CON_PE]                    = r_pe;
    w_con[CON_PAR_LO+1:CON_PAR_LO]   = r_par;
    w_con[CON_TWO_STOP]              = r_two;
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (w_hit_rxd && !w_rxf_empty) rdata[7:0]       = w_rxf_data;
      else if (w_hit_con)            rdata            = w_con;
      else if (w_hit_div)            rdata[DIV_W-1:0] = r_div;
    end
  end

endmodule

// File: tb/tb_uart_fifo_unit.sv
// Directed bench for uart_fifo_unit: register map, 8N1 TX waveform, TX FIFO
// overflow, RX parity/overrun/framing/glitch, irq and asynchronous reset.
module tb_uart_fifo_unit;
  localparam logic [31:0] A_TXD = 32'h40000018;
  localparam logic [31:0] A_RXD = 32'h4000001C;
  localparam logic [31:0] A_CON = 32'h40000020;
  localparam logic [31:0] A_DIV = 32'h40000024;

  logic        CLK = 1'b0, Reset_n = 1'b0, rd = 1'b0, wr = 1'b0, in = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        out, irq;
  int          total = 0, bad = 0;

  uart_fifo_unit dut (
    .CLK(CLK), .Reset_n(Reset_n), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .out(out), .in(in), .irq(irq));

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge CLK); wr = 1'b1; addr = a; wdata = d;
    @(posedge CLK); #1 wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge CLK); rd = 1'b1; addr = a;
    #1 d = rdata;
    @(posedge CLK); #1 rd = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic [1:0] pm, input bit flip, input bit stopv);
    logic p;
    p = ((pm == 2'b10) ? ~^b : ^b) ^ flip;
    @(negedge CLK); in = 1'b0; repeat (16) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin in = b[i]; repeat (16) @(negedge CLK); end
    if (pm == 2'b01 || pm == 2'b10) begin in = p; repeat (16) @(negedge CLK); end
    in = stopv; repeat (16) @(negedge CLK);
    in = 1'b1;  repeat (16) @(negedge CLK);
  endtask

  // Waits (bounded) for a start bit on out, then samples each bit mid-cell.
  task automatic get_frame(input int limit, output logic [7:0] d, output bit ok, output int nwait);
    nwait = 0; ok = 0; d = '0;
    do begin @(negedge CLK); nwait++; end while (out !== 1'b0 && nwait < limit);
    if (out === 1'b0) begin
      repeat (8) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin repeat (16) @(negedge CLK); d[i] = out; end
      repeat (16) @(negedge CLK);
      ok = (out === 1'b1);
    end
  endtask

  initial begin
    logic [9:0]  pat;
    logic [7:0]  fd;
    bit          fok;
    int          n, errs, nframes;

    // ---- reset state ----
    repeat (3) @(negedge CLK);
    chk("rst_out", out, 1);
    chk("rst_irq", irq, 0);
    chk("rst_rdata", rdata, 0);
    Reset_n = 1'b1;
    rd_chk("rst_con", A_CON, 32'h004);
    rd_chk("rst_div", A_DIV, 31);
    rd_chk("unmapped", A_DIV + 32'd4, 0);
    rd_chk("txd_read", A_TXD, 0);
    rd_chk("rxd_empty", A_RXD, 0);
    bus_wr(A_DIV, 0);
    rd_chk("div_wr", A_DIV, 0);

    // ---- 8N1 TX of 0xA5, bit-exact waveform ----
    pat = {1'b1, 8'hA5, 1'b0};
    bus_wr(A_TXD, 32'hA5);
    n = 0;
    do begin @(negedge CLK); n++; end while (out !== 1'b0 && n < 50);
    chk("tx_latency", n, 2);
    errs = 0;
    for (int k = 0; k < 160; k++) begin
      if (out !== pat[k/16]) errs++;
      @(negedge CLK);
    end
    chk("tx_wave_errs", errs, 0);
    rd_chk("tx_empty_after", A_CON, 32'h004);

    // ---- 10 writes into a busy TX: 9 frames, back-to-back ----
    nframes = 0;
    fork
      begin
        logic [31:0] c;
        for (int i = 0; i < 10; i++) bus_wr(A_TXD, 32'h10 + i);
        bus_rd(A_CON, c);
        chk("tx_full_busy", c, 32'h030);
      end
      begin
        for (int i = 0; i < 9; i++) begin
          get_frame(400, fd, fok, n);
          chk("tx_frame_ok", fok, 1);
          chk("tx_frame_data", fd, 8'h10 + i);
          if (i > 0) chk("tx_gap", n, 8);
          if (fok) nframes++;
        end
        get_frame(400, fd, fok, n);
        chk("tx_dropped", fok, 0);
      end
    join
    chk("tx_nframes", nframes, 9);

    // ---- RX with even parity ----
    bus_wr(A_CON, 32'h200);
    send_rx(8'h3C, 2'b01, 0, 1);
    rd_chk("rx_par_con", A_CON, 32'h20C);
    rd_chk("rx_par_data", A_RXD, 32'h3C);
    send_rx(8'h3C, 2'b01, 1, 1);
    rd_chk("rx_perr_con", A_CON, 32'h30C);
    rd_chk("rx_perr_data", A_RXD, 32'h3C);
    bus_wr(A_CON, 32'h300);
    rd_chk("rx_perr_w1c", A_CON, 32'h204);

    // ---- overrun ----
    bus_wr(A_CON, 0);
    for (int i = 0; i < 9; i++) send_rx(8'h40 + i, 2'b00, 0, 1);
    rd_chk("ovr_con", A_CON, 32'h04C);
    for (int i = 0; i < 8; i++) rd_chk("ovr_data", A_RXD, 32'h40 + i);
    rd_chk("ovr_drained", A_RXD, 0);
    bus_wr(A_CON, 32'h040);
    rd_chk("ovr_w1c", A_CON, 32'h004);

    // ---- framing error ----
    send_rx(8'h55, 2'b00, 0, 0);
    rd_chk("fe_con", A_CON, 32'h084);
    rd_chk("fe_nopush", A_RXD, 0);
    bus_wr(A_CON, 32'h080);

    // ---- 4-CLK glitch ----
    @(negedge CLK); in = 1'b0; repeat (4) @(negedge CLK); in = 1'b1;
    repeat (200) @(negedge CLK);
    rd_chk("glitch_con", A_CON, 32'h004);

    // ---- irq ----
    bus_wr(A_CON, 32'h002);
    repeat (2) @(negedge CLK);
    chk("irq_idle", irq, 0);
    send_rx(8'h81, 2'b00, 0, 1);
    chk("irq_rx", irq, 1);
    rd_chk("irq_data", A_RXD, 32'h81);
    repeat (2) @(negedge CLK);
    chk("irq_clr", irq, 0);
    bus_wr(A_CON, 32'h001);
    repeat (2) @(negedge CLK);
    chk("irq_tx_empty", irq, 1);
    bus_wr(A_CON, 0);

    // ---- asynchronous reset mid-TX ----
    send_rx(8'h11, 2'b00, 0, 1);
    bus_wr(A_TXD, 0);
    bus_wr(A_TXD, 0);
    repeat (40) @(negedge CLK);
    chk("mid_tx_low", out, 0);
    #2 Reset_n = 1'b0;
    #1 chk("arst_out", out, 1);
    chk("arst_irq", irq, 0);
    @(negedge CLK); Reset_n = 1'b1;
    rd_chk("arst_con", A_CON, 32'h004);
    rd_chk("arst_rxd", A_RXD, 0);
    rd_chk("arst_div", A_DIV, 31);
    errs = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (out !== 1'b1) errs++;
    end
    chk("arst_tx_quiet", errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
